// File: rtl/vending_ctrl_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : vending_ctrl_multi_if
// Description : Front-panel / dispenser signal bundle for vending_ctrl_multi.
// Revision    : 1.0 - initial release
// ============================================================================
interface vending_ctrl_multi_if #(
    parameter int NUM_PRODUCTS = 4,
    parameter int MONEY_W      = 5
);
    logic                    Input_Money;
    logic                    Req_Change;
    logic [NUM_PRODUCTS-1:0] Click;
    logic [MONEY_W-1:0]      Money;
    logic [MONEY_W-1:0]      Change;
    logic                    Change_Pulse;
    logic [NUM_PRODUCTS-1:0] Dispense;
    logic                    Busy;
    logic                    Reject;

    modport master (
        output Input_Money, Req_Change, Click,
        input  Money, Change, Change_Pulse, Dispense, Busy, Reject
    );

    modport slave (
        input  Input_Money, Req_Change, Click,
        output Money, Change, Change_Pulse, Dispense, Busy, Reject
    );
endinterface
`default_nettype wire

// File: rtl/vending_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module      : vending_ctrl_multi
// Description : Multi-product vending controller: credit, purchase, refund.
// Revision    : 1.0 - initial release
// ============================================================================
module vending_ctrl_multi #(
    parameter int                            NUM_PRODUCTS    = 4,
    parameter int                            MONEY_W         = 5,
    parameter int                            MAX_CREDIT      = 16,
    parameter logic [NUM_PRODUCTS*MONEY_W-1:0] PRICES        = {5'd2, 5'd2, 5'd3, 5'd4},
    parameter int                            DISPENSE_CYCLES = 2,
    parameter int                            TIMEOUT_CYCLES  = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    vending_ctrl_multi_if.slave   bus
);
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_DISPENSE = 2'd1;
    localparam logic [1:0] c_ST_REFUND   = 2'd2;

    localparam int c_DCNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
    localparam int c_TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_DCNT_W-1:0] c_DCNT_LAST = c_DCNT_W'(DISPENSE_CYCLES - 1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_LAST =
        c_TCNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [MONEY_W-1:0]  c_MAX_CREDIT = MONEY_W'(MAX_CREDIT);

    logic [1:0]              r_state;
    logic [MONEY_W-1:0]      r_money;
    logic [MONEY_W-1:0]      r_change;
    logic [NUM_PRODUCTS-1:0] r_dispense;
    logic                    r_busy;
    logic                    r_reject;
    logic [c_DCNT_W-1:0]     r_dcnt;
    logic [c_TCNT_W-1:0]     r_tcnt;

    logic [NUM_PRODUCTS-1:0] w_click_oh;
    logic [MONEY_W-1:0]      w_price;
    logic                    w_any_click;
    logic                    w_quiet;
    logic                    w_timeout;

    // Scan from the top so the lowest set button wins.
    always_comb begin
        w_click_oh = '0;
        w_price    = '0;
        for (int i = NUM_PRODUCTS - 1; i >= 0; i--) begin
            if (bus.Click[i]) begin
                w_click_oh = NUM_PRODUCTS'(1) << i;
                w_price    = PRICES[i*MONEY_W +: MONEY_W];
            end
        end
    end

    assign w_any_click = |bus.Click;
    assign w_quiet     = !bus.Input_Money && !w_any_click && !bus.Req_Change;
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && w_quiet &&
                         (r_money != '0) && (r_tcnt == c_TCNT_LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= c_ST_IDLE;
            r_money    <= '0;
            r_change   <= '0;
            r_dispense <= '0;
            r_busy     <= 1'b0;
            r_reject   <= 1'b0;
            r_dcnt     <= '0;
            r_tcnt     <= '0;
        end else begin
            r_reject <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.Input_Money) begin
                        r_tcnt <= '0;
                        if (r_money < c_MAX_CREDIT) r_money  <= r_money + 1'b1;
                        else                        r_reject <= 1'b1;
                    end else if (w_any_click) begin
                        r_tcnt <= '0;
                        if (r_money >= w_price) begin
                            r_money    <= r_money - w_price;
                            r_dispense <= w_click_oh;
                            r_busy     <= 1'b1;
                            r_dcnt     <= '0;
                            r_state    <= c_ST_DISPENSE;
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end else if ((bus.Req_Change && r_money != '0) || w_timeout) begin
                        r_change <= r_money;
                        r_money  <= '0;
                        r_busy   <= 1'b1;
                        r_tcnt   <= '0;
                        r_state  <= c_ST_REFUND;
                    end else if (bus.Req_Change || r_money == '0) begin
                        r_tcnt <= '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                c_ST_DISPENSE: begin
                    if (bus.Input_Money) r_reject <= 1'b1;
                    if (r_dcnt == c_DCNT_LAST) begin
                        r_dispense <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= c_ST_IDLE;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                c_ST_REFUND: begin
                    if (bus.Input_Money) r_reject <= 1'b1;
                    if (r_change != '0) r_change <= r_change - 1'b1;
                    // Leave on the edge that returns the last unit.
                    if (r_change <= MONEY_W'(1)) begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_dispense <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Money        = r_money;
    assign bus.Change       = r_change;
    assign bus.Dispense     = r_dispense;
    assign bus.Busy         = r_busy;
    assign bus.Reject       = r_reject;
    assign bus.Change_Pulse = (r_state == c_ST_REFUND) && (r_change != '0);
endmodule
`default_nettype wire

// File: tb/tb_vending_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_vending_ctrl_multi
// Description : Self-checking bench for vending_ctrl_multi (queue scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_ctrl_multi;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_q[$];
    int   rej_q[$];

    always #5 Clock = ~Clock;

    vending_ctrl_multi_if #(.NUM_PRODUCTS(4), .MONEY_W(5)) bus  ();
    vending_ctrl_multi_if #(.NUM_PRODUCTS(4), .MONEY_W(5)) busz ();

    vending_ctrl_multi #(
        .NUM_PRODUCTS(4), .MONEY_W(5), .MAX_CREDIT(16),
        .PRICES({5'd2, 5'd2, 5'd3, 5'd4}),
        .DISPENSE_CYCLES(2), .TIMEOUT_CYCLES(3)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    vending_ctrl_multi #(
        .NUM_PRODUCTS(4), .MONEY_W(5), .MAX_CREDIT(16),
        .PRICES({5'd2, 5'd2, 5'd3, 5'd4}),
        .DISPENSE_CYCLES(2), .TIMEOUT_CYCLES(0)
    ) dut_noto (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (busz)
    );

    // Inputs are applied 1 ns after an edge; outputs are read 1 ns after the next.
    task automatic step(input logic coin, input logic [3:0] click, input logic req);
        bus.Input_Money = coin;
        bus.Click       = click;
        bus.Req_Change  = req;
        @(posedge Clock);
        #1;
        bus.Input_Money = 1'b0;
        bus.Click       = 4'b0;
        bus.Req_Change  = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        n_cmp++; if (bus.Money !== 5'd0)   begin n_err++; $display("FAIL rst_money actual=%0d required=0", bus.Money); end
        n_cmp++; if (bus.Change !== 5'd0)  begin n_err++; $display("FAIL rst_change actual=%0d required=0", bus.Change); end
        n_cmp++; if (bus.Dispense !== 4'b0) begin n_err++; $display("FAIL rst_dispense actual=%b required=0000", bus.Dispense); end
        n_cmp++; if (bus.Busy !== 1'b0)    begin n_err++; $display("FAIL rst_busy actual=%b required=0", bus.Busy); end
        n_cmp++; if (bus.Reject !== 1'b0)  begin n_err++; $display("FAIL rst_reject actual=%b required=0", bus.Reject); end
        n_cmp++; if (bus.Change_Pulse !== 1'b0) begin n_err++; $display("FAIL rst_pulse actual=%b required=0", bus.Change_Pulse); end
        Reset = 1'b0;
    endtask

    task automatic test_purchase();
        int e;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(i);
            step(1'b1, 4'b0, 1'b0);
            e = exp_q.pop_front();
            n_cmp++; if (bus.Money !== 5'(e)) begin n_err++; $display("FAIL buy_coin_money actual=%0d required=%0d", bus.Money, e); end
        end
        exp_q.push_back(0);
        step(1'b0, 4'b0010, 1'b0);
        e = exp_q.pop_front();
        n_cmp++; if (bus.Money !== 5'(e)) begin n_err++; $display("FAIL buy_money actual=%0d required=%0d", bus.Money, e); end
        for (int c = 0; c < 3; c++) begin
            logic [3:0] ed;
            logic       eb;
            ed = (c < 2) ? 4'b0010 : 4'b0000;
            eb = (c < 2);
            n_cmp++; if (bus.Dispense !== ed) begin n_err++; $display("FAIL buy_dispense_c%0d actual=%b required=%b", c, bus.Dispense, ed); end
            n_cmp++; if (bus.Busy !== eb)     begin n_err++; $display("FAIL buy_busy_c%0d actual=%b required=%b", c, bus.Busy, eb); end
            n_cmp++; if (bus.Reject !== 1'b0) begin n_err++; $display("FAIL buy_reject_c%0d actual=%b required=0", c, bus.Reject); end
            if (c < 2) step(1'b0, 4'b0, 1'b0);
        end
    endtask

    task automatic test_reject_price();
        step(1'b1, 4'b0, 1'b0);
        step(1'b1, 4'b0, 1'b0);
        step(1'b0, 4'b0001, 1'b0);
        n_cmp++; if (bus.Reject !== 1'b1) begin n_err++; $display("FAIL price_reject actual=%b required=1", bus.Reject); end
        n_cmp++; if (bus.Money !== 5'd2)  begin n_err++; $display("FAIL price_money actual=%0d required=2", bus.Money); end
        n_cmp++; if (bus.Busy !== 1'b0)   begin n_err++; $display("FAIL price_busy actual=%b required=0", bus.Busy); end
        step(1'b0, 4'b0, 1'b0);
        n_cmp++; if (bus.Reject !== 1'b0) begin n_err++; $display("FAIL price_reject_once actual=%b required=0", bus.Reject); end
        step(1'b0, 4'b1100, 1'b0);
        n_cmp++; if (bus.Money !== 5'd0)       begin n_err++; $display("FAIL lowsel_money actual=%0d required=0", bus.Money); end
        n_cmp++; if (bus.Dispense !== 4'b0100) begin n_err++; $display("FAIL lowsel_dispense actual=%b required=0100", bus.Dispense); end
        step(1'b0, 4'b0, 1'b0);
        step(1'b0, 4'b0, 1'b0);
    endtask

    task automatic count_pulses(input string name, input int expected);
        int pulses = 0;
        int guard  = 0;
        while (bus.Change_Pulse === 1'b1 && guard < 40) begin
            pulses++;
            guard++;
            step(1'b0, 4'b0, 1'b0);
        end
        n_cmp++; if (pulses != expected) begin n_err++; $display("FAIL %s_pulses actual=%0d required=%0d", name, pulses, expected); end
        n_cmp++; if (bus.Busy !== 1'b0)   begin n_err++; $display("FAIL %s_busy_end actual=%b required=0", name, bus.Busy); end
        n_cmp++; if (bus.Change !== 5'd0) begin n_err++; $display("FAIL %s_change_end actual=%0d required=0", name, bus.Change); end
        n_cmp++; if (bus.Money !== 5'd0)  begin n_err++; $display("FAIL %s_money_end actual=%0d required=0", name, bus.Money); end
    endtask

    task automatic test_saturate();
        int e;
        int r;
        for (int i = 1; i <= 18; i++) begin
            exp_q.push_back((i > 16) ? 16 : i);
            rej_q.push_back((i > 16) ? 1 : 0);
            step(1'b1, 4'b0, 1'b0);
            e = exp_q.pop_front();
            r = rej_q.pop_front();
            n_cmp++; if (bus.Money !== 5'(e))  begin n_err++; $display("FAIL sat_money_%0d actual=%0d required=%0d", i, bus.Money, e); end
            n_cmp++; if (bus.Reject !== 1'(r)) begin n_err++; $display("FAIL sat_reject_%0d actual=%b required=%0d", i, bus.Reject, r); end
        end
        step(1'b0, 4'b0, 1'b1);
        n_cmp++; if (bus.Change !== 5'd16) begin n_err++; $display("FAIL sat_change actual=%0d required=16", bus.Change); end
        n_cmp++; if (bus.Money !== 5'd0)   begin n_err++; $display("FAIL sat_refund_money actual=%0d required=0", bus.Money); end
        n_cmp++; if (bus.Busy !== 1'b1)    begin n_err++; $display("FAIL sat_refund_busy actual=%b required=1", bus.Busy); end
        count_pulses("sat", 16);
    endtask

    task automatic test_timeout();
        busz.Input_Money = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0, 1'b0);
        busz.Input_Money = 1'b0;
        n_cmp++; if (bus.Money !== 5'd5) begin n_err++; $display("FAIL to_money actual=%0d required=5", bus.Money); end
        for (int q = 1; q <= 3; q++) begin
            step(1'b0, 4'b0, 1'b0);
            if (q < 3) begin
                n_cmp++; if (bus.Change !== 5'd0) begin n_err++; $display("FAIL to_early_q%0d actual=%0d required=0", q, bus.Change); end
            end else begin
                n_cmp++; if (bus.Change !== 5'd5) begin n_err++; $display("FAIL to_change actual=%0d required=5", bus.Change); end
            end
        end
        count_pulses("to", 5);
        repeat (20) step(1'b0, 4'b0, 1'b0);
        n_cmp++; if (busz.Money !== 5'd5)  begin n_err++; $display("FAIL noto_money actual=%0d required=5", busz.Money); end
        n_cmp++; if (busz.Change !== 5'd0) begin n_err++; $display("FAIL noto_change actual=%0d required=0", busz.Change); end
        n_cmp++; if (busz.Busy !== 1'b0)   begin n_err++; $display("FAIL noto_busy actual=%b required=0", busz.Busy); end
    endtask

    task automatic test_coin_click();
        step(1'b1, 4'b0001, 1'b0);
        n_cmp++; if (bus.Money !== 5'd1)    begin n_err++; $display("FAIL both_money actual=%0d required=1", bus.Money); end
        n_cmp++; if (bus.Dispense !== 4'b0) begin n_err++; $display("FAIL both_dispense actual=%b required=0000", bus.Dispense); end
        n_cmp++; if (bus.Reject !== 1'b0)   begin n_err++; $display("FAIL both_reject actual=%b required=0", bus.Reject); end
        step(1'b1, 4'b0, 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        n_cmp++; if (bus.Dispense !== 4'b1000) begin n_err++; $display("FAIL disp_sel actual=%b required=1000", bus.Dispense); end
        step(1'b1, 4'b0, 1'b0);
        n_cmp++; if (bus.Reject !== 1'b1) begin n_err++; $display("FAIL disp_coin_reject actual=%b required=1", bus.Reject); end
        n_cmp++; if (bus.Money !== 5'd0)  begin n_err++; $display("FAIL disp_coin_money actual=%0d required=0", bus.Money); end
        step(1'b0, 4'b0, 1'b0);
        n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL disp_end_busy actual=%b required=0", bus.Busy); end
    endtask

    task automatic test_reset_mid_refund();
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0, 1'b0);
        step(1'b0, 4'b0, 1'b1);
        step(1'b0, 4'b0, 1'b0);
        step(1'b0, 4'b0, 1'b0);
        n_cmp++; if (bus.Change !== 5'd3) begin n_err++; $display("FAIL mid_change actual=%0d required=3", bus.Change); end
        #2 Reset = 1'b1;
        #1;
        n_cmp++; if (bus.Change !== 5'd0)       begin n_err++; $display("FAIL arst_change actual=%0d required=0", bus.Change); end
        n_cmp++; if (bus.Busy !== 1'b0)         begin n_err++; $display("FAIL arst_busy actual=%b required=0", bus.Busy); end
        n_cmp++; if (bus.Change_Pulse !== 1'b0) begin n_err++; $display("FAIL arst_pulse actual=%b required=0", bus.Change_Pulse); end
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        step(1'b0, 4'b0, 1'b0);
        n_cmp++; if (bus.Change_Pulse !== 1'b0) begin n_err++; $display("FAIL post_rst_pulse actual=%b required=0", bus.Change_Pulse); end
        step(1'b1, 4'b0, 1'b0);
        n_cmp++; if (bus.Money !== 5'd1) begin n_err++; $display("FAIL post_rst_coin actual=%0d required=1", bus.Money); end
    endtask

    initial begin
        bus.Input_Money  = 1'b0;
        bus.Click        = 4'b0;
        bus.Req_Change   = 1'b0;
        busz.Input_Money = 1'b0;
        busz.Click       = 4'b0;
        busz.Req_Change  = 1'b0;
        test_reset();
        test_purchase();
        test_reject_price();
        test_saturate();
        test_timeout();
        test_coin_click();
        test_reset_mid_refund();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
